// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: round-robin arbiter with grant locking; optional forced release under `ARB_TIMEOUT_EN
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   req_i[N]        level requests, held for the whole transaction
//   done_i[N]       one-cycle release pulse from the owner (other bits ignored)
//   gnt_o[N]        registered one-hot grant or zero
//   gnt_valid_o     OR of gnt_o
//   gnt_id_o[ID_W]  index of the current owner, holds while no grant
//   timeout_pulse_o one-cycle pulse on a forced release (0 without ARB_TIMEOUT_EN)
module rr_lock_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    done_i,
  output logic [N-1:0]    gnt_o,
  output logic            gnt_valid_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            timeout_pulse_o
);
  if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_lock_arbiter: N must be 2..16 and MAX_HOLD >= 1");
  end
  typedef enum logic {IDLE, OWNED} state_t;
  state_t          state_q;
  logic [ID_W-1:0] owner_q, ptr_q, nxt_ptr, start, win;
  logic [N-1:0]    cand;
  logic            quit, forced, take, found;
  assign nxt_ptr     = ID_W'((int'(owner_q) + 1) % N);
  assign quit        = state_q == OWNED && (done_i[owner_q] || !req_i[owner_q]);
  assign take        = state_q == IDLE || quit || forced;
  // On release the current owner is masked out so it can never win back-to-back
  assign start       = state_q == OWNED ? nxt_ptr : ptr_q;
  assign cand        = state_q == OWNED ? req_i & ~(N'(1) << owner_q) : req_i;
  assign gnt_valid_o = |gnt_o;
`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q;
  logic          sat;
  assign sat    = hold_q == HW'(MAX_HOLD - 1);
  // done/abandon take precedence, so a coinciding timeout is not flagged
  assign forced = state_q == OWNED && !quit && sat && |cand;
`else
  assign forced = 1'b0;
`endif
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[(int'(start) + i) % N]) begin
        found = 1'b1;
        win   = ID_W'((int'(start) + i) % N);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      owner_q         <= '0;
      ptr_q           <= '0;
      gnt_o           <= '0;
      gnt_id_o        <= '0;
      timeout_pulse_o <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q          <= '0;
`endif
    end else begin
      timeout_pulse_o <= forced;
      if (take) begin
        if (state_q == OWNED) ptr_q <= nxt_ptr;
        state_q <= found ? OWNED : IDLE;
        gnt_o   <= found ? N'(1) << win : '0;
        if (found) begin
          owner_q  <= win;
          gnt_id_o <= win;
        end
      end
`ifdef ARB_TIMEOUT_EN
      if (take) hold_q <= '0;
      else if (!sat) hold_q <= hold_q + HW'(1);
`endif
    end
  end
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter: directed and randomized checks of rr_lock_arbiter against a behavioural model
module tb_rr_lock_arbiter;
  localparam int N = 4;
  localparam int MAX_HOLD = 8;
  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, done, gnt;
  logic         gnt_valid, tp;
  logic [1:0]   gnt_id;
  int           checks = 0;
  int           errors = 0;
  bit           m_busy;
  int           m_own, m_ptr, m_hold, m_id;
  logic [N-1:0] m_gnt;
  bit           m_tp;
  rr_lock_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req_i(req), .done_i(done),
    .gnt_o(gnt), .gnt_valid_o(gnt_valid), .gnt_id_o(gnt_id), .timeout_pulse_o(tp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int first_from(input logic [N-1:0] c, input int s);
    for (int k = 0; k < N; k++) if (c[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction
  task automatic model(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
    bit rel, to;
    logic [N-1:0] c;
    int s, w;
    if (r) begin
      m_busy = 0; m_ptr = 0; m_hold = 0; m_gnt = '0; m_id = 0; m_tp = 0;
      return;
    end
    rel = m_busy && (dn[m_own] || !rq[m_own]);
    to = 0;
`ifdef ARB_TIMEOUT_EN
    c = rq;
    c[m_own] = 1'b0;
    to = m_busy && !rel && m_hold == MAX_HOLD - 1 && c != '0;
`endif
    m_tp = to;
    if (!m_busy || rel || to) begin
      c = rq;
      s = m_ptr;
      if (m_busy) begin
        c[m_own] = 1'b0;
        s = (m_own + 1) % N;
        m_ptr = s;
      end
      w = first_from(c, s);
      m_hold = 0;
      if (w >= 0) begin
        m_busy = 1; m_own = w; m_gnt = N'(1) << w; m_id = w;
      end else begin
        m_busy = 0; m_gnt = '0;
      end
    end else if (m_hold < MAX_HOLD - 1) m_hold++;
  endtask
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
    rst = r; req = rq; done = dn;
    model(r, rq, dn);
    @(posedge clk);
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("gnt_valid", 32'(gnt_valid), 32'(|m_gnt));
    chk("gnt_id", 32'(gnt_id), 32'(m_id));
    chk("timeout_pulse", 32'(tp), 32'(m_tp));
  endtask
  initial begin
    logic [N-1:0] rq, dn;
    m_own = 0;
    step(1, 4'b1111, 4'b0000);
    step(1, 4'b1111, 4'b0000);
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_id", 32'(gnt_id), 32'h0);
    step(0, 4'b1111, 4'b0000);
    chk("rot_first", 32'(gnt), 32'b0001);
    for (int k = 0; k < 4; k++) begin
      step(0, 4'b1111, 4'b0000);
      step(0, 4'b1111, 4'b0000);
      step(0, 4'b1111, gnt);
      chk("rot_next", 32'(gnt), 32'(4'b0001 << ((k + 1) % 4)));
    end
    step(1, 4'b0000, 4'b0000);
    step(0, 4'b0100, 4'b0000);
    chk("lock_grant", 32'(gnt), 32'b0100);
    for (int k = 0; k < 20; k++) step(0, 4'b0101, 4'b0000);
`ifndef ARB_TIMEOUT_EN
    chk("lock_hold", 32'(gnt), 32'b0100);
    step(0, 4'b0101, 4'b0100);
    chk("lock_release", 32'(gnt), 32'b0001);
    step(0, 4'b0010, 4'b0001);
    chk("owner1", 32'(gnt), 32'b0010);
    step(0, 4'b0000, 4'b0000);
    chk("abandon_idle", 32'(gnt), 32'b0000);
    step(0, 4'b0011, 4'b0000);
    chk("ptr_wrap", 32'(gnt), 32'b0001);
    step(0, 4'b0001, 4'b0001);
    step(0, 4'b0001, 4'b0000);
    chk("no_back_to_back_gap", 32'(gnt), 32'b0001);
`else
    for (int rep = 0; rep < 2; rep++) begin
      step(1, 4'b0000, 4'b0000);
      step(0, 4'b0001, 4'b0000);
      for (int k = 0; k < 7; k++) step(0, 4'b0101, 4'b0000);
      chk("to_not_yet", 32'(gnt), 32'b0001);
      step(0, 4'b0101, rep == 1 ? 4'b0001 : 4'b0000);
      chk("to_switch", 32'(gnt), 32'b0100);
      chk("to_pulse", 32'(tp), rep == 1 ? 32'h0 : 32'h1);
    end
`endif
    step(1, 4'b0000, 4'b0000);
    step(0, 4'b0100, 4'b0000);
    step(1, 4'b0100, 4'b0000);
    chk("mid_reset", 32'(gnt), 32'b0000);
    step(0, 4'b1111, 4'b0000);
    chk("after_reset", 32'(gnt), 32'b0001);
    rq = 4'b1111;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      dn = '0;
      if ($urandom_range(0, 3) == 0) dn = m_gnt;
      if ($urandom_range(0, 3) == 0) dn = dn | N'($urandom);
      step($urandom_range(0, 199) == 0, rq, dn);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
